weight_control: RTL and testbench
=================================

WEIGHT_CONTROL -- requirements
Module: weight_control

Interface
REQ-001 Parameter MATRIX_WIDTH, default 14, gives the systolic array dimension and the number of bytes per weight row.
REQ-002 Parameter ROW_CNT_WIDTH, default $clog2(MATRIX_WIDTH+1), gives the width of the row-count field.
REQ-003 Ports SHALL be, clock and reset first:
  clk  in  1  single clock; all logic on posedge.
  rst  in  1  synchronous, active-high reset.
  enable  in  1  global pipeline advance; low freezes all state.
  instr_valid  in  1  load-weights instruction offered.
  instr_ready  out  1  high when IDLE; instruction accepted on instr_valid&instr_ready&enable.
  instr_weight_addr  in  weight_addr_type  base weight-buffer address.
  instr_row_count  in  ROW_CNT_WIDTH  rows to load.
  instr_signed  in  1  weights are signed.
  busy  out  1  high in any state other than IDLE.
  wb_addr  out  weight_addr_type  weight-buffer port address.
  wb_en  out  1  weight-buffer port enable.
  wb_read_port  in  byte_type [MATRIX_WIDTH-1:0]  weight-buffer read data.
  mmu_weight_data  out  byte_type [MATRIX_WIDTH-1:0]  row to the array.
  mmu_weight_row  out  $clog2(MATRIX_WIDTH)  destination row index.
  mmu_weight_load  out  1  one-cycle row-valid strobe.
  mmu_weight_signed  out  1  signedness latched at accept.
  done  out  1  one-cycle pulse after the last row strobe.

Function
REQ-004 The FSM SHALL have states IDLE, FETCH and DRAIN, and every transition SHALL require enable=1.
REQ-005 On accept, the block SHALL latch addr, signed, and count=min(instr_row_count, MATRIX_WIDTH), then enter FETCH; a count of 0 SHALL go to DRAIN with no reads.
REQ-006 In FETCH, the block SHALL issue one read per enabled cycle at base+i for i=0..count-1, with wb_en=1 and row tag i.
REQ-007 The address increment SHALL wrap modulo 2^WEIGHT_ADDR_WIDTH.
REQ-008 wb_en SHALL equal (state==FETCH)&enable, so a stalled cycle never updates the buffer's read register.
REQ-009 After the last issue, the block SHALL enter DRAIN.
REQ-010 Read latency SHALL be WEIGHT_READ_LATENCY=3 enabled cycles, tracked by a 3-stage valid/row shift register that advances only when enable=1.
REQ-011 When the tail stage is valid and enable=1, mmu_weight_load SHALL be 1, mmu_weight_data=wb_read_port (combinational pass-through), and mmu_weight_row=tag.
REQ-012 When enable=0, mmu_weight_load SHALL be 0.
REQ-013 In DRAIN, when the shift register is empty, the block SHALL pulse done for one cycle and return to IDLE.
REQ-014 A new instruction SHALL be accepted no earlier than the cycle after done.
REQ-015 instr_valid while busy SHALL be ignored and SHALL NOT be latched.
REQ-016 Rows SHALL be delivered in order, exactly once each, with no gaps while enable stays high.
REQ-017 An N-row load SHALL take N+3 cycles from accept to the last strobe when enable is held high.
REQ-018 mmu_weight_signed SHALL hold its value from accept until the next accept.

Reset
REQ-019 rst SHALL override enable.
REQ-020 rst SHALL force state=IDLE, clear the shift register, and drive wb_en=0, mmu_weight_load=0, done=0, busy=0, instr_ready=1, wb_addr=0, mmu_weight_row=0 and mmu_weight_signed=0.
REQ-021 A reset mid-load SHALL abort the load with no further strobes and no done pulse.

Structure
REQ-022 weight_addr_type, byte_type, BYTE_WIDTH and WEIGHT_READ_LATENCY SHALL live in tpu_pkg.
REQ-023 The block SHALL be a single module with no sub-modules; the latency shift register SHALL be inline.

Verification
REQ-024 A bench SHALL cover each of the following directed scenarios against a 14-wide weight buffer model, with row k preloaded as byte k = 0x80 and all other bytes 0:
  Basic load: addr=0, count=14, enable=1 -> 14 strobes, rows 0..13 in order with byte k=0x80; first strobe 3 cycles after the first wb_en; done 1 cycle after the last strobe.
  Clamp: count=15 -> exactly 14 reads and 14 strobes.
  Zero count: count=0 -> no wb_en, no strobes, done within 2 cycles.
  Wrap: addr=max-1, count=3 -> wb_addr sequence max-1, max, 0.
  Stall: enable low for 2 cycles mid-FETCH -> wb_en=0 and no strobes while low; rows resume without loss or duplication; total latency grows by 2.
  Back-to-back and reset: instr_valid held high -> second accept only after done; rst asserted in cycle 5 -> no further strobes, instr_ready=1 on the next cycle.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU types: byte lanes, weight-buffer addressing and read latency.
// Pure declarations; no logic lives here.
package tpu_pkg;

  localparam int BYTE_WIDTH          = 8;
  localparam int WEIGHT_ADDR_WIDTH   = 8;
  localparam int WEIGHT_READ_LATENCY = 3;

  typedef logic [BYTE_WIDTH-1:0]        byte_type;
  typedef logic [WEIGHT_ADDR_WIDTH-1:0] weight_addr_type;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } wc_state_e;

endpackage

// File: rtl/weight_control.sv
// Streams up to MATRIX_WIDTH weight rows from the weight buffer into the array; rows land WEIGHT_READ_LATENCY enabled cycles after issue.
// enable=0 freezes every register and suppresses reads/strobes; new instructions are only taken in IDLE.
module weight_control
  import tpu_pkg::*;
#(
  parameter int MATRIX_WIDTH  = 14,
  parameter int ROW_CNT_WIDTH = $clog2(MATRIX_WIDTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              instr_valid,
  output logic                              instr_ready,
  input  weight_addr_type                   instr_weight_addr,
  input  logic [ROW_CNT_WIDTH-1:0]          instr_row_count,
  input  logic                              instr_signed,
  output logic                              busy,
  output weight_addr_type                   wb_addr,
  output logic                              wb_en,
  input  byte_type [MATRIX_WIDTH-1:0]       wb_read_port,
  output byte_type [MATRIX_WIDTH-1:0]       mmu_weight_data,
  output logic [$clog2(MATRIX_WIDTH)-1:0]   mmu_weight_row,
  output logic                              mmu_weight_load,
  output logic                              mmu_weight_signed,
  output logic                              done
);

  localparam int ROW_W = $clog2(MATRIX_WIDTH);
  localparam int LAT   = WEIGHT_READ_LATENCY;
  localparam logic [ROW_CNT_WIDTH-1:0] MAX_ROWS = ROW_CNT_WIDTH'(MATRIX_WIDTH);

  wc_state_e                state_q, state_d;
  weight_addr_type          addr_q, addr_d;
  logic [ROW_CNT_WIDTH-1:0] idx_q, idx_d;
  logic [ROW_CNT_WIDTH-1:0] count_q, count_d;
  logic                     signed_q, signed_d;
  logic [LAT-1:0]           vld_q, vld_d;
  logic [ROW_W-1:0]         row_q [LAT];
  logic [ROW_W-1:0]         row_d [LAT];

  logic [ROW_CNT_WIDTH-1:0] req_count;
  logic                     accept;
  logic                     issue;
  logic                     last_issue;
  logic                     pipe_empty;

  assign req_count  = (instr_row_count > MAX_ROWS) ? MAX_ROWS : instr_row_count;
  assign accept     = (state_q == ST_IDLE) && instr_valid && enable;
  assign issue      = (state_q == ST_FETCH) && enable;
  assign last_issue = (idx_q == count_q - 1'b1);
  assign pipe_empty = (vld_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        ST_IDLE:  if (instr_valid) state_d = (req_count == '0) ? ST_DRAIN : ST_FETCH;
        ST_FETCH: if (last_issue)  state_d = ST_DRAIN;
        ST_DRAIN: if (pipe_empty)  state_d = ST_IDLE;
        default:                   state_d = ST_IDLE;
      endcase
    end
  end

  // Read-issue bookkeeping plus the valid/row-tag shadow of the buffer's read pipeline.
  always_comb begin
    addr_d   = addr_q;
    idx_d    = idx_q;
    count_d  = count_q;
    signed_d = signed_q;
    vld_d    = vld_q;
    for (int i = 0; i < LAT; i++) row_d[i] = row_q[i];

    if (accept) begin
      addr_d   = instr_weight_addr;
      idx_d    = '0;
      count_d  = req_count;
      signed_d = instr_signed;
    end else if (issue) begin
      addr_d = addr_q + 1'b1;
      idx_d  = idx_q + 1'b1;
    end

    if (enable) begin
      vld_d    = {vld_q[LAT-2:0], issue};
      row_d[0] = idx_q[ROW_W-1:0];
      for (int i = 1; i < LAT; i++) row_d[i] = row_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      signed_q <= 1'b0;
      vld_q    <= '0;
      for (int i = 0; i < LAT; i++) row_q[i] <= '0;
    end else begin
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      signed_q <= signed_d;
      vld_q    <= vld_d;
      row_q    <= row_d;
    end
  end

  // Outputs are forced to their idle values while rst is high, even before state has cleared.
  always_comb begin
    instr_ready       = 1'b1;
    busy              = 1'b0;
    wb_en             = 1'b0;
    wb_addr           = '0;
    mmu_weight_load   = 1'b0;
    mmu_weight_row    = '0;
    mmu_weight_signed = 1'b0;
    done              = 1'b0;
    if (!rst) begin
      instr_ready       = (state_q == ST_IDLE);
      busy              = (state_q != ST_IDLE);
      wb_en             = issue;
      wb_addr           = addr_q;
      mmu_weight_load   = vld_q[LAT-1] && enable;
      mmu_weight_row    = row_q[LAT-1];
      mmu_weight_signed = signed_q;
      done              = (state_q == ST_DRAIN) && pipe_empty && enable;
    end
  end

  assign mmu_weight_data = wb_read_port;

endmodule

// File: tb/tb_weight_control.sv
// Directed bench for weight_control against a 3-stage weight-buffer model.
// Row k of the buffer holds 0x80 in byte k; every other byte is zero.
module tb_weight_control;
  import tpu_pkg::*;

  localparam int MW  = 14;
  localparam int RCW = $clog2(MW + 1);
  localparam int RW  = $clog2(MW);
  localparam int DW  = MW * BYTE_WIDTH;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              instr_valid;
  logic              instr_ready;
  weight_addr_type   instr_weight_addr;
  logic [RCW-1:0]    instr_row_count;
  logic              instr_signed;
  logic              busy;
  weight_addr_type   wb_addr;
  logic              wb_en;
  byte_type [MW-1:0] wb_read_port;
  byte_type [MW-1:0] mmu_weight_data;
  logic [RW-1:0]     mmu_weight_row;
  logic              mmu_weight_load;
  logic              mmu_weight_signed;
  logic              done;

  weight_control #(.MATRIX_WIDTH(MW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_weight_addr(instr_weight_addr), .instr_row_count(instr_row_count),
    .instr_signed(instr_signed), .busy(busy),
    .wb_addr(wb_addr), .wb_en(wb_en), .wb_read_port(wb_read_port),
    .mmu_weight_data(mmu_weight_data), .mmu_weight_row(mmu_weight_row),
    .mmu_weight_load(mmu_weight_load), .mmu_weight_signed(mmu_weight_signed),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] golden(input int a);
    logic [DW-1:0] d;
    d = '0;
    if (a < MW) d[a*8 +: 8] = 8'h80;
    return d;
  endfunction

  // Weight buffer: registered read on wb_en, then two more stages, all frozen by enable=0.
  logic [DW-1:0] p0, p1, p2;
  always @(posedge clk) begin
    if (enable) begin
      if (wb_en) p0 <= golden(int'(wb_addr));
      p1 <= p0;
      p2 <= p1;
    end
  end
  assign wb_read_port = p2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int bad_en = 0;
  int s_ready, s_busy, s_wb_en, s_load, s_done, s_addr, s_row, s_signed;
  int acc_q[$];
  int wba_q[$];
  int wbc_q[$];
  int rowq[$];
  int stb_q[$];
  int done_q[$];
  logic [DW-1:0] dat_q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample everything at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_ready  = int'(instr_ready);
    s_busy   = int'(busy);
    s_wb_en  = int'(wb_en);
    s_load   = int'(mmu_weight_load);
    s_done   = int'(done);
    s_addr   = int'(wb_addr);
    s_row    = int'(mmu_weight_row);
    s_signed = int'(mmu_weight_signed);
    if (instr_valid && instr_ready && enable && !rst) acc_q.push_back(cyc);
    if (wb_en) begin
      wba_q.push_back(int'(wb_addr));
      wbc_q.push_back(cyc);
    end
    if (mmu_weight_load) begin
      rowq.push_back(int'(mmu_weight_row));
      dat_q.push_back(mmu_weight_data);
      stb_q.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    if (!enable && (wb_en || mmu_weight_load)) bad_en++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    acc_q.delete(); wba_q.delete(); wbc_q.delete();
    rowq.delete(); stb_q.delete(); done_q.delete(); dat_q.delete();
  endtask

  task automatic send(input int addr, input int cnt, input logic sgn);
    instr_weight_addr = weight_addr_type'(addr);
    instr_row_count   = RCW'(cnt);
    instr_signed      = sgn;
    instr_valid       = 1'b1;
    tick();
    instr_valid       = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_q.size() == 0; i++) tick();
    chk({tag, "_done_seen"}, done_q.size(), 1);
  endtask

  task automatic check_load(input string tag, input int base, input int n, input int acc, input int fst_lat);
    chk({tag, "_reads"}, wba_q.size(), n);
    chk({tag, "_strobes"}, rowq.size(), n);
    for (int i = 0; i < n && i < wba_q.size(); i++)
      chk({tag, "_wb_addr"}, wba_q[i], (base + i) % 256);
    for (int i = 0; i < n && i < rowq.size(); i++) begin
      chk({tag, "_row"}, rowq[i], i);
      chkd({tag, "_data"}, dat_q[i], golden((base + i) % 256));
    end
    if (wbc_q.size() > 0 && stb_q.size() > 0) begin
      chk({tag, "_first_read"}, wbc_q[0] - acc, 1);
      chk({tag, "_first_strobe"}, stb_q[0] - wbc_q[0], fst_lat);
    end
  endtask

  initial begin
    int a;
    int last;

    rst = 1'b1; enable = 1'b1; instr_valid = 1'b0; instr_signed = 1'b0;
    instr_weight_addr = '0; instr_row_count = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", s_ready, 1);
    chk("rst_busy", s_busy, 0);
    chk("rst_wb_en", s_wb_en, 0);
    chk("rst_load", s_load, 0);
    chk("rst_done", s_done, 0);
    chk("rst_wb_addr", s_addr, 0);
    chk("rst_row", s_row, 0);
    chk("rst_signed", s_signed, 0);

    // Basic 14-row load.
    clear_rec();
    send(0, 14, 1'b1);
    run_until_done("basic", 40);
    chk("basic_accepts", acc_q.size(), 1);
    a = (acc_q.size() > 0) ? acc_q[0] : 0;
    check_load("basic", 0, 14, a, 3);
    last = (stb_q.size() > 0) ? stb_q[$] : 0;
    chk("basic_last_latency", last - a, 17);
    chk("basic_done_cycle", (done_q.size() > 0) ? done_q[0] : -1, last + 1);
    tick();
    chk("basic_signed_held", s_signed, 1);
    chk("basic_idle_ready", s_ready, 1);

    // Count above MATRIX_WIDTH is clamped.
    clear_rec();
    send(0, 15, 1'b0);
    run_until_done("clamp", 40);
    a = (acc_q.size() > 0) ? acc_q[0] : 0;
    check_load("clamp", 0, 14, a, 3);
    chk("clamp_signed", s_signed, 0);

    // Zero rows: straight to done, no reads.
    clear_rec();
    send(5, 0, 1'b1);
    run_until_done("zero", 5);
    a = (acc_q.size() > 0) ? acc_q[0] : 0;
    chk("zero_reads", wba_q.size(), 0);
    chk("zero_strobes", rowq.size(), 0);
    chk("zero_done_within_2", int'(done_q.size() > 0 && done_q[0] - a <= 2), 1);

    // Address wraps past the top of the buffer.
    clear_rec();
    send(254, 3, 1'b0);
    run_until_done("wrap", 20);
    a = (acc_q.size() > 0) ? acc_q[0] : 0;
    check_load("wrap", 254, 3, a, 3);

    // Two-cycle stall after the first two issues.
    clear_rec();
    send(0, 6, 1'b0);
    a = (acc_q.size() > 0) ? acc_q[0] : 0;
    tick(); tick();
    enable = 1'b0;
    tick(); tick();
    enable = 1'b1;
    run_until_done("stall", 40);
    check_load("stall", 0, 6, a, 5);
    chk("stall_quiet_while_low", bad_en, 0);
    last = (stb_q.size() > 0) ? stb_q[$] : 0;
    chk("stall_last_latency", last - a, 11);
    chk("stall_done_cycle", (done_q.size() > 0) ? done_q[0] : -1, last + 1);

    // Back-to-back with instr_valid held, then reset in the second load.
    clear_rec();
    instr_weight_addr = '0; instr_row_count = RCW'(14); instr_signed = 1'b1;
    instr_valid = 1'b1;
    for (int i = 0; i < 60 && acc_q.size() < 2; i++) tick();
    instr_valid = 1'b0;
    chk("b2b_accepts", acc_q.size(), 2);
    chk("b2b_accept_after_done",
        (acc_q.size() == 2 && done_q.size() == 1) ? acc_q[1] - done_q[0] : -1, 1);
    chk("b2b_first_strobes", rowq.size(), 14);
    tick(); tick(); tick(); tick();
    chk("b2b_second_started", rowq.size(), 15);
    clear_rec();
    rst = 1'b1;
    tick();
    chk("midrst_no_strobe", s_load, 0);
    rst = 1'b0;
    tick();
    chk("midrst_ready", s_ready, 1);
    chk("midrst_busy", s_busy, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("midrst_strobes", rowq.size(), 0);
    chk("midrst_done", done_q.size(), 0);
    chk("midrst_reads", wba_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
